alu_core: RTL and testbench

- Registered, single-cycle-latency arithmetic/logic unit with two unsigned DATA_WIDTH operands and a 2*DATA_WIDTH result.
- Used as the datapath execution unit inside the system controller.
- Operation is selected by a 4-bit function code and is sampled only while enable is high.
- Result and a valid strobe appear on the clock edge after the operands are sampled.

---
 rtl/alu_core.sv | 104 ++++++++++
 tb/tb_alu_core.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : Registered ALU with one cycle of latency. Two unsigned
//            DATA_WIDTH operands give a 2*DATA_WIDTH result. The
//            operation is selected by a 4-bit function code.
// Ports    : clk              - system clock, rising-edge active
//            reset            - synchronous, active-high; wins over enable
//            A, B             - unsigned operands, sampled while enable=1
//            ALU_function     - operation select
//            enable           - sample operands and register a result
//            ALU_result       - registered result (2*DATA_WIDTH)
//            ALU_result_valid - high the cycle after an enabled cycle
// Revision : 1.0 - initial release
// ============================================================================
module alu_core #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_WIDTH-1:0]     A,
   input  logic [DATA_WIDTH-1:0]     B,
   input  logic [3:0]                ALU_function,
   input  logic                      enable,
   output logic [2*DATA_WIDTH-1:0]   ALU_result,
   output logic                      ALU_result_valid
);

   localparam int c_RW = 2 * DATA_WIDTH;

   localparam logic [3:0] c_FN_ADD  = 4'b0000;
   localparam logic [3:0] c_FN_SUB  = 4'b0001;
   localparam logic [3:0] c_FN_MUL  = 4'b0010;
   localparam logic [3:0] c_FN_DIV  = 4'b0011;
   localparam logic [3:0] c_FN_AND  = 4'b0100;
   localparam logic [3:0] c_FN_OR   = 4'b0101;
   localparam logic [3:0] c_FN_NAND = 4'b0110;
   localparam logic [3:0] c_FN_NOR  = 4'b0111;
   localparam logic [3:0] c_FN_XOR  = 4'b1000;
   localparam logic [3:0] c_FN_XNOR = 4'b1001;
   localparam logic [3:0] c_FN_EQ   = 4'b1010;
   localparam logic [3:0] c_FN_GT   = 4'b1011;
   localparam logic [3:0] c_FN_LT   = 4'b1100;
   localparam logic [3:0] c_FN_SHR  = 4'b1101;
   localparam logic [3:0] c_FN_SHL  = 4'b1110;

   localparam logic [DATA_WIDTH-1:0] c_HI_ZERO = '0;

   logic [c_RW-1:0] w_a_ext;
   logic [c_RW-1:0] w_b_ext;
   logic [c_RW-1:0] w_quot;
   logic [c_RW-1:0] w_next;
   logic [c_RW-1:0] r_result;
   logic            r_valid;

   // Zero-extend so carry, borrow wrap and the full product fit the result.
   assign w_a_ext = {c_HI_ZERO, A};
   assign w_b_ext = {c_HI_ZERO, B};

   // Divide-by-zero is defined to give 0 rather than relying on tool behaviour.
   assign w_quot = (B == c_HI_ZERO) ? '0 : (w_a_ext / w_b_ext);

   always_comb begin
      w_next = '0;
      case (ALU_function)
         c_FN_ADD:  w_next = w_a_ext + w_b_ext;
         c_FN_SUB:  w_next = w_a_ext - w_b_ext;
         c_FN_MUL:  w_next = w_a_ext * w_b_ext;
         c_FN_DIV:  w_next = w_quot;
         c_FN_AND:  w_next = {c_HI_ZERO, A & B};
         c_FN_OR:   w_next = {c_HI_ZERO, A | B};
         // Inverting ops are confined to the low half; upper bits stay 0.
         c_FN_NAND: w_next = {c_HI_ZERO, ~(A & B)};
         c_FN_NOR:  w_next = {c_HI_ZERO, ~(A | B)};
         c_FN_XOR:  w_next = {c_HI_ZERO, A ^ B};
         c_FN_XNOR: w_next = {c_HI_ZERO, ~(A ^ B)};
         c_FN_EQ:   w_next = {{(c_RW-1){1'b0}}, (A == B)};
         c_FN_GT:   w_next = {{(c_RW-1){1'b0}}, (A > B)};
         c_FN_LT:   w_next = {{(c_RW-1){1'b0}}, (A < B)};
         c_FN_SHR:  w_next = w_a_ext >> 1;
         // The extended operand keeps the shifted-out MSB in bit DATA_WIDTH.
         c_FN_SHL:  w_next = w_a_ext << 1;
         default:   w_next = '0;
      endcase
   end

   // The result holds while disabled; valid pulses only after enabled cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_result <= '0;
         r_valid  <= 1'b0;
      end else if (enable) begin
         r_result <= w_next;
         r_valid  <= 1'b1;
      end else begin
         r_valid  <= 1'b0;
      end
   end

   assign ALU_result       = r_result;
   assign ALU_result_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_core
// Purpose  : Self-checking bench for alu_core. Expected results are queued
//            when an enabled operation is driven and popped when the
//            valid strobe appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_core;

   localparam int DW = 8;

   logic            clk;
   logic            reset;
   logic [DW-1:0]   A;
   logic [DW-1:0]   B;
   logic [3:0]      ALU_function;
   logic            enable;
   logic [2*DW-1:0] ALU_result;
   logic            ALU_result_valid;

   int              n_cmp;
   int              n_fail;
   logic [2*DW-1:0] exp_q[$];
   logic [2*DW-1:0] held;

   alu_core #(.DATA_WIDTH(DW)) dut (
      .clk              (clk),
      .reset            (reset),
      .A                (A),
      .B                (B),
      .ALU_function     (ALU_function),
      .enable           (enable),
      .ALU_result       (ALU_result),
      .ALU_result_valid (ALU_result_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model written in plain integer arithmetic.
   function automatic logic [2*DW-1:0] model(input int a, input int b, input int fn);
      int r;
      case (fn)
         0:  r = a + b;
         1:  r = a - b + 65536;
         2:  r = a * b;
         3:  r = (b == 0) ? 0 : a / b;
         4:  r = a & b;
         5:  r = a | b;
         6:  r = 255 - (a & b);
         7:  r = 255 - (a | b);
         8:  r = a ^ b;
         9:  r = 255 - (a ^ b);
         10: r = (a == b) ? 1 : 0;
         11: r = (a > b) ? 1 : 0;
         12: r = (a < b) ? 1 : 0;
         13: r = a / 2;
         14: r = a * 2;
         default: r = 0;
      endcase
      return 16'(r % 65536);
   endfunction

   task automatic check(input string tag, input logic [2*DW-1:0] obs, input logic [2*DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock step: drive, clock, then check valid and result.
   task automatic step(input string tag, input logic rst, input logic en,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [3:0] fn, input logic [2*DW-1:0] exp);
      logic [2*DW-1:0] e;
      reset        = rst;
      enable       = en;
      A            = a;
      B            = b;
      ALU_function = fn;
      if (!rst && en) exp_q.push_back(exp);
      @(posedge clk);
      #1;
      check({tag, ".valid"}, {15'd0, ALU_result_valid}, {15'd0, (!rst && en)});
      if (rst) begin
         exp_q.delete();
         held = '0;
         check({tag, ".rst"}, ALU_result, 16'h0000);
      end else if (en) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed=%h expected=<scoreboard empty>", tag, ALU_result);
         end else begin
            e = exp_q.pop_front();
            held = e;
            check(tag, ALU_result, e);
         end
      end else begin
         check({tag, ".hold"}, ALU_result, held);
      end
      @(negedge clk);
   endtask

   initial begin
      logic [DW-1:0] ra;
      logic [DW-1:0] rb;
      logic [3:0]    rf;
      logic          ren;
      n_cmp  = 0;
      n_fail = 0;
      held   = '0;
      reset = 1'b0; enable = 1'b0; A = '0; B = '0; ALU_function = '0;

      step("reset",    1, 0, 8'h00, 8'h00, 4'h0, 16'h0000);
      step("add",      0, 1, 8'h54, 8'h2A, 4'h0, 16'h007E);
      step("add_cy",   0, 1, 8'hFF, 8'hFF, 4'h0, 16'h01FE);
      step("sub",      0, 1, 8'h54, 8'h2A, 4'h1, 16'h002A);
      step("sub_wrap", 0, 1, 8'h10, 8'h20, 4'h1, 16'hFFF0);
      step("mul",      0, 1, 8'h54, 8'h2A, 4'h2, 16'h0DC8);
      step("mul_max",  0, 1, 8'hFF, 8'hFF, 4'h2, 16'hFE01);
      step("div",      0, 1, 8'h54, 8'h2A, 4'h3, 16'h0002);
      step("div0",     0, 1, 8'h54, 8'h00, 4'h3, 16'h0000);
      step("and",      0, 1, 8'h54, 8'h2F, 4'h4, 16'h0004);
      step("or",       0, 1, 8'hF4, 8'h2C, 4'h5, 16'h00FC);
      step("nand",     0, 1, 8'h54, 8'h2F, 4'h6, 16'h00FB);
      step("nor",      0, 1, 8'hF4, 8'h2C, 4'h7, 16'h0003);
      step("xor",      0, 1, 8'hF4, 8'h2C, 4'h8, 16'h00D8);
      step("xnor",     0, 1, 8'hF4, 8'h2C, 4'h9, 16'h0027);
      step("eq_t",     0, 1, 8'h33, 8'h33, 4'hA, 16'h0001);
      step("eq_f",     0, 1, 8'h33, 8'h34, 4'hA, 16'h0000);
      step("gt",       0, 1, 8'h80, 8'h7F, 4'hB, 16'h0001);
      step("lt",       0, 1, 8'h80, 8'h7F, 4'hC, 16'h0000);
      step("shl",      0, 1, 8'h80, 8'h7F, 4'hE, 16'h0100);
      step("shr",      0, 1, 8'h80, 8'h7F, 4'hD, 16'h0040);
      step("fn_f",     0, 1, 8'hAA, 8'h55, 4'hF, 16'h0000);
      step("add2",     0, 1, 8'h01, 8'h02, 4'h0, 16'h0003);
      step("dis1",     0, 0, 8'hFF, 8'h01, 4'h2, 16'h0000);
      step("dis2",     0, 0, 8'h12, 8'h34, 4'h0, 16'h0000);
      step("re_en",    0, 1, 8'h7F, 8'h01, 4'h0, 16'h0080);
      step("rst_en",   1, 1, 8'h54, 8'h2A, 4'h2, 16'h0DC8);
      step("post_rst", 0, 0, 8'h54, 8'h2A, 4'h2, 16'h0000);

      for (int i = 0; i < 48; i++) begin
         ra  = DW'($urandom_range(0, 255));
         rb  = DW'($urandom_range(0, 255));
         rf  = 4'($urandom_range(0, 15));
         ren = ($urandom_range(0, 3) != 0);
         step("rand", 0, ren, ra, rb, rf, model(int'(ra), int'(rb), int'(rf)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
